// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus bundle for the register-file write-port arbiter: two writeback
// sources, the source-B issue notification, decode lookups and the write port.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic [4:0]      a_addr;
  logic [XLEN-1:0] a_data;
  logic            a_ready;

  logic            b_valid;
  logic [4:0]      b_addr;
  logic [XLEN-1:0] b_data;
  logic            b_ready;

  logic            issue_valid;
  logic [4:0]      issue_addr;

  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;

  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  // Pipeline / decode side: presents writebacks and lookups, sees grants.
  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output issue_valid, issue_addr,
    output rs1_addr, rs2_addr, rd_addr,
    input  rs1_busy, rs2_busy, rd_busy,
    input  wr_en, wr_addr, wr_data
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  issue_valid, issue_addr,
    input  rs1_addr, rs2_addr, rd_addr,
    output rs1_busy, rs2_busy, rd_busy,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. Source A (in-order pipeline) has priority;
// source B (long-latency unit) is forced through after STARVE_MAX lost cycles.
// A scoreboard tracks registers with outstanding source-B writes for decode.
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_wb_arbiter_if.slave wb
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     pending_q, pending_d;

  logic            a_ready, b_ready;
  logic            a_hs, b_hs;

  logic            wr_en_p1;
  logic [4:0]      wr_addr_p1;
  logic [XLEN-1:0] wr_data_p1;

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant selection, starvation counting and next-state decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_ready = 1'b1;
    b_ready = !wb.a_valid;
    if (state_q == FORCE_B) begin
      a_ready = 1'b0;
      b_ready = 1'b1;
    end
    a_hs = wb.a_valid && a_ready;
    b_hs = wb.b_valid && b_ready;

    if (!wb.b_valid || b_hs) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      NORMAL:  if (cnt_d == CNT_MAX) state_d = FORCE_B;
      // Either B handshakes here or has dropped valid; both end the force.
      FORCE_B: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Scoreboard update: B handshake clears, issue sets, set wins, x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (b_hs) pending_d[wb.b_addr] = 1'b0;
    if (wb.issue_valid && (wb.issue_addr != 5'd0)) pending_d[wb.issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard pending-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Stage p1: register the granted writeback onto the register-file port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else if (a_hs) begin
      wr_en_p1 <= (wb.a_addr != 5'd0);
      if (wb.a_addr != 5'd0) begin
        wr_addr_p1 <= wb.a_addr;
        wr_data_p1 <= wb.a_data;
      end
    end else if (b_hs) begin
      wr_en_p1 <= (wb.b_addr != 5'd0);
      if (wb.b_addr != 5'd0) begin
        wr_addr_p1 <= wb.b_addr;
        wr_data_p1 <= wb.b_data;
      end
    end else begin
      wr_en_p1 <= 1'b0;
    end
  end

  assign wb.a_ready  = a_ready;
  assign wb.b_ready  = b_ready;
  assign wb.wr_en    = wr_en_p1;
  assign wb.wr_addr  = wr_addr_p1;
  assign wb.wr_data  = wr_data_p1;
  assign wb.rs1_busy = pending_q[wb.rs1_addr];
  assign wb.rs2_busy = pending_q[wb.rs2_addr];
  assign wb.rd_busy  = pending_q[wb.rd_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with STARVE_MAX=4, XLEN=32.
module tb_rf_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  rf_wb_arbiter_if #(.XLEN(32)) wb ();

  rf_wb_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n = 1'b0;
    wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = '0; wb.b_data = '0;
    wb.issue_valid = 1'b0; wb.issue_addr = '0;
    wb.rs1_addr = '0; wb.rs2_addr = '0; wb.rd_addr = '0;

    // Reset state
    #3;
    check("rst_wr_en", wb.wr_en, 0);
    check("rst_wr_addr", wb.wr_addr, 0);
    check("rst_wr_data", wb.wr_data, 0);
    check("rst_a_ready", wb.a_ready, 1);
    check("rst_b_ready_idle", wb.b_ready, 1);
    check("rst_busy", {wb.rs1_busy, wb.rs2_busy, wb.rd_busy}, 0);
    wb.a_valid = 1'b1;
    #1;
    check("rst_b_ready_a_valid", wb.b_ready, 0);
    wb.a_valid = 1'b0;
    #8;
    rst_n = 1'b1;
    tick;

    // A writes x5 with B idle
    wb.a_valid = 1'b1; wb.a_addr = 5'd5; wb.a_data = 32'hDEADBEEF;
    #1;
    check("a_only_a_ready", wb.a_ready, 1);
    tick;
    wb.a_valid = 1'b0;
    check("a_only_wr_en", wb.wr_en, 1);
    check("a_only_wr_addr", wb.wr_addr, 5);
    check("a_only_wr_data", wb.wr_data, 32'hDEADBEEF);
    tick;
    check("idle_wr_en", wb.wr_en, 0);
    check("idle_wr_addr_hold", wb.wr_addr, 5);

    // Issue x9, busy appears next cycle, cleared after B writes x9
    wb.issue_valid = 1'b1; wb.issue_addr = 5'd9; wb.rs1_addr = 5'd9;
    #1;
    check("issue_no_bypass", wb.rs1_busy, 0);
    tick;
    wb.issue_valid = 1'b0;
    check("issue_busy", wb.rs1_busy, 1);
    wb.b_valid = 1'b1; wb.b_addr = 5'd9; wb.b_data = 32'h0000_0099;
    #1;
    check("b9_b_ready", wb.b_ready, 1);
    check("b9_busy_same_cycle", wb.rs1_busy, 1);
    tick;
    wb.b_valid = 1'b0;
    check("b9_wr_en", wb.wr_en, 1);
    check("b9_wr_addr", wb.wr_addr, 9);
    check("b9_wr_data", wb.wr_data, 32'h99);
    check("b9_busy_cleared", wb.rs1_busy, 0);

    // Starvation: A continuous, B x7 denied 4 cycles then forced
    wb.a_valid = 1'b1; wb.a_addr = 5'd1; wb.a_data = 32'h11;
    wb.b_valid = 1'b1; wb.b_addr = 5'd7; wb.b_data = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve7_b_ready_%0d", i), wb.b_ready, 0);
      check($sformatf("starve7_a_ready_%0d", i), wb.a_ready, 1);
      tick;
      check($sformatf("starve7_a_write_%0d", i), wb.wr_addr, 1);
    end
    #1;
    check("force7_a_ready", wb.a_ready, 0);
    check("force7_b_ready", wb.b_ready, 1);
    tick;
    check("force7_wr_en", wb.wr_en, 1);
    check("force7_wr_addr", wb.wr_addr, 7);
    check("force7_wr_data", wb.wr_data, 32'h1234);

    // Counter restarted from 0: next B again waits 4 full cycles
    wb.b_addr = 5'd8; wb.b_data = 32'h5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve8_b_ready_%0d", i), wb.b_ready, 0);
      tick;
    end
    #1;
    check("force8_b_ready", wb.b_ready, 1);
    tick;
    wb.a_valid = 1'b0; wb.b_valid = 1'b0;
    check("force8_wr_addr", wb.wr_addr, 8);

    // Same-cycle set and clear on x3: set wins
    wb.issue_valid = 1'b1; wb.issue_addr = 5'd3; wb.rd_addr = 5'd3;
    tick;
    wb.issue_valid = 1'b0;
    check("x3_pending", wb.rd_busy, 1);
    wb.issue_valid = 1'b1; wb.issue_addr = 5'd3;
    wb.b_valid = 1'b1; wb.b_addr = 5'd3; wb.b_data = 32'h33;
    #1;
    check("x3_b_ready", wb.b_ready, 1);
    tick;
    wb.issue_valid = 1'b0; wb.b_valid = 1'b0;
    check("x3_set_wins", wb.rd_busy, 1);
    check("x3_wr_addr", wb.wr_addr, 3);

    // A writes x0, issue to x0
    wb.a_valid = 1'b1; wb.a_addr = 5'd0; wb.a_data = 32'hFFFFFFFF;
    wb.issue_valid = 1'b1; wb.issue_addr = 5'd0; wb.rs2_addr = 5'd0;
    #1;
    check("x0_a_ready", wb.a_ready, 1);
    tick;
    wb.a_valid = 1'b0; wb.issue_valid = 1'b0;
    check("x0_wr_en", wb.wr_en, 0);
    check("x0_wr_data_hold", wb.wr_data, 32'h33);
    check("x0_wr_addr_hold", wb.wr_addr, 3);
    check("x0_no_busy", wb.rs2_busy, 0);

    // FORCE_B with an A write in flight, then asynchronous reset
    wb.a_valid = 1'b1; wb.a_addr = 5'd2; wb.a_data = 32'h22;
    wb.b_valid = 1'b1; wb.b_addr = 5'd4; wb.b_data = 32'h44;
    for (int i = 0; i < 4; i++) tick;
    check("pre_rst_wr_en", wb.wr_en, 1);
    check("pre_rst_force_a_ready", wb.a_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", wb.wr_en, 0);
    check("async_rst_busy", {wb.rs1_busy, wb.rs2_busy, wb.rd_busy}, 0);
    check("async_rst_a_ready", wb.a_ready, 1);
    check("async_rst_b_ready", wb.b_ready, 0);
    #2;
    rst_n = 1'b1;
    tick;
    #1;
    check("post_rst_a_ready", wb.a_ready, 1);
    check("post_rst_b_ready", wb.b_ready, 0);
    wb.a_valid = 1'b0; wb.b_valid = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32-entry integer register file. It shares the register file's single write port between two writeback sources: the in-order pipeline (source A) and a long-latency unit such as mul/div or load (source B). It also keeps a pending-write scoreboard so the decode stage can stall on registers that source B has not yet written. It sits between the writeback stage and the register file's wr_en/wr_addr/wr_data inputs.

## Interface
- XLEN, 32, data width
- STARVE_MAX, 4, consecutive cycles source B may lose arbitration before it is forced through (≥1)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- a_valid  in  1  source A has a writeback
- a_addr  in  5  source A destination register
- a_data  in  XLEN  source A result
- a_ready  out  1  source A writeback accepted this cycle
- b_valid  in  1  source B has a writeback; must hold until b_ready
- b_addr  in  5  source B destination register
- b_data  in  XLEN  source B result
- b_ready  out  1  source B writeback accepted this cycle
- issue_valid  in  1  an instruction destined for source B issues this cycle
- issue_addr  in  5  destination register of that instruction
- rs1_addr, rs2_addr, rd_addr  in  5 each  decode-stage lookup addresses
- rs1_busy, rs2_busy, rd_busy  out  1 each  addressed register has a pending source-B write
- wr_en  out  1  register-file write enable
- wr_addr  out  5  register-file write address
- wr_data  out  XLEN  register-file write data

## Operation
- FSM has two states:
  - NORMAL: a_ready=1, b_ready=!a_valid. Source A has priority.
  - FORCE_B: b_ready=1, a_ready=0.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Increments each cycle with b_valid && !b_ready.
  - Clears when b_valid=0 or when a B handshake completes.
- NORMAL→FORCE_B when the counter reaches STARVE_MAX on the posedge.
- FORCE_B→NORMAL after the B handshake, which always occurs in the first FORCE_B cycle. The counter clears at that point.
- If b_valid=0 in FORCE_B (a protocol violation), return to NORMAL and clear the counter.
- Exactly one handshake per cycle at most. The granted source's addr/data are registered to wr_addr/wr_data. wr_en=1 when granted and addr≠0.
- A handshake with addr=0 is accepted (ready=1), but wr_en stays 0 and wr_addr/wr_data hold their previous values.
- No handshake in a cycle: wr_en=0 next cycle; wr_addr/wr_data hold.
- Scoreboard: 32 pending bits.
  - issue_valid with issue_addr≠0 sets bit[issue_addr].
  - A B handshake clears bit[b_addr].
  - Same-cycle set and clear on the same address: set wins.
  - Bit 0 is never set.
- Busy outputs are combinational reads of the pending bits, based on the flop state before the edge. There is no bypass of same-cycle issue or clear.
- Source A writes to a pending register are not checked. Decode must stall on rd_busy, so a WAW with B cannot reach this block.

## Timing
- Reset values (asynchronous): wr_en=0, wr_addr=0, wr_data=0, all pending bits 0, counter 0, state NORMAL.
  - Consequently a_ready=1, b_ready=!a_valid, and all busy outputs 0 during reset.
- a_ready, b_ready and busy outputs are combinational from inputs and state, with zero latency.
- Write latency: handshake at posedge N drives wr_en/wr_addr/wr_data valid from N to N+1. The register file commits on the negedge inside that cycle.
- Scoreboard set/clear is visible on busy outputs from the cycle after the edge.
- Worst-case B wait with A valid every cycle: STARVE_MAX cycles in NORMAL, then accepted in the 1st FORCE_B cycle, for STARVE_MAX+1 cycles total.
- A stalls at most 1 cycle per forced B grant.
- rst_n asserted mid-operation: an in-flight wr_en drops immediately and pending bits clear. Requesters re-present after reset.

## Test plan
- Reset, then A writes x5=0xDEADBEEF with B idle → a_ready=1, and next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- Both valid, A continuous, B x7=0x1234, STARVE_MAX=4 → B denied 4 cycles, accepted on the 5th with a_ready=0 that cycle; next cycle wr_addr=7, wr_data=0x1234; counter back to 0.
- issue_valid x9, then rs1_addr=9 → rs1_busy=1 from the next cycle. B handshake on x9 → rs1_busy=0 the cycle after.
- Same cycle: issue x3 and B completes x3 (previously pending) → bit 3 stays set, rd_busy(3)=1.
- A writes x0=0xFFFFFFFF and issue_valid with issue_addr=0 → a_ready=1, wr_en stays 0, wr_data unchanged; no busy bit set.
- FORCE_B with wr_en=1 in flight, rst_n pulsed low asynchronously → wr_en=0 immediately, all busy=0, state NORMAL after release.
